// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
//  - ALU data/opcode widths
//  - opcode constants understood by the external 32-bit ALU
//  - sequencer FSM state encoding
//  - opcode legality helper
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    // Arithmetic group (opcode[3] = 1)
    localparam logic [OP_W-1:0] OP_ADD = 4'b1111;
    localparam logic [OP_W-1:0] OP_SUB = 4'b1110;
    localparam logic [OP_W-1:0] OP_INC = 4'b1101;
    localparam logic [OP_W-1:0] OP_DEC = 4'b1100;
    // Logic group (opcode[3] = 0)
    localparam logic [OP_W-1:0] OP_AND = 4'b0111;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0101;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

    // Every supported opcode has bit 2 set; anything else never reaches the ALU.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO holding queued ALU commands.
//  clk    in   clock, rising edge
//  rst_n  in   asynchronous active-low reset (empties the FIFO)
//  push   in   write wdata (ignored when full)
//  wdata  in   entry to write
//  pop    in   drop head entry (ignored when empty)
//  rdata  out  head entry, valid whenever !empty (first-word fall-through)
//  full   out  count == DEPTH
//  empty  out  count == 0
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == COUNT_FULL);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Storage carries no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side master for the external 32-bit combinational ALU.
// Queues commands, drives them one at a time onto the ALU bus, waits ALU_LAT cycles,
// then captures result/carry and returns them tagged on a valid/ready response port.
//  clk, rst_n                   clock / asynchronous active-low reset
//  cmd_valid/ready              command handshake; cmd_opcode, cmd_a, cmd_b, cmd_tag payload
//  alu_status                   ALU enable, high only while a command is being driven
//  alu_a, alu_b, alu_opcode     registered ALU operands (hold last values when idle)
//  alu_result, alu_cout         ALU outputs, sampled at the end of the settle time
//  rsp_valid/ready              response handshake; rsp_result, rsp_cout, rsp_tag, rsp_illegal payload
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              alu_status,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_cout,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_illegal
);

    localparam int ENTRY_W = OP_W + 2 * DATA_W + TAG_W;
    localparam int CNT_W   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(ALU_LAT - 1);

    seq_state_e         state_q;
    logic [CNT_W-1:0]   settle_q;
    logic [TAG_W-1:0]   tag_q;
    logic               alu_status_q;
    logic [DATA_W-1:0]  alu_a_q;
    logic [DATA_W-1:0]  alu_b_q;
    logic [OP_W-1:0]    alu_opcode_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_result_q;
    logic               rsp_cout_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic               rsp_illegal_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [OP_W-1:0]    head_op;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [TAG_W-1:0]   head_tag;

    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && !fifo_full;
    assign fifo_wdata = {cmd_opcode, cmd_a, cmd_b, cmd_tag};
    assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

    // The head is taken either from idle or on the same edge a response is consumed,
    // which gives back-to-back issue without an IDLE bubble.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            tag_q         <= '0;
            alu_status_q  <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_opcode_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_cout_q    <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Issue handled below when fifo_pop is set.
                end
                ST_DRIVE: begin
                    if (settle_q == '0) begin
                        alu_status_q  <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_result_q  <= alu_result;
                        rsp_cout_q    <= alu_cout;
                        rsp_tag_q     <= tag_q;
                        rsp_illegal_q <= 1'b0;
                        state_q       <= ST_RESP;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Issue overrides the state/response updates above.
            if (fifo_pop) begin
                tag_q <= head_tag;
                if (op_is_legal(head_op)) begin
                    alu_status_q <= 1'b1;
                    alu_a_q      <= head_a;
                    alu_b_q      <= head_b;
                    alu_opcode_q <= head_op;
                    settle_q     <= SETTLE_INIT;
                    state_q      <= ST_DRIVE;
                end else begin
                    // Unsupported opcode: answered directly, ALU bus left untouched.
                    rsp_valid_q   <= 1'b1;
                    rsp_result_q  <= '0;
                    rsp_cout_q    <= 1'b0;
                    rsp_tag_q     <= head_tag;
                    rsp_illegal_q <= 1'b1;
                    state_q       <= ST_RESP;
                end
            end
        end
    end

    assign alu_status  = alu_status_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_opcode_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_cout    = rsp_cout_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic        cout;
        logic [3:0]  tag;
        logic        illegal;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT with ALU_LAT=1
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_tag;
    logic        alu_status;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_cout;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_illegal;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;

    // DUT with ALU_LAT=3
    logic        l3_cmd_valid, l3_cmd_ready;
    logic [3:0]  l3_cmd_opcode;
    logic [31:0] l3_cmd_a, l3_cmd_b;
    logic [3:0]  l3_cmd_tag;
    logic        l3_alu_status;
    logic [31:0] l3_alu_a, l3_alu_b, l3_alu_result;
    logic [3:0]  l3_alu_opcode;
    logic        l3_alu_cout;
    logic        l3_rsp_valid, l3_rsp_ready, l3_rsp_cout, l3_rsp_illegal;
    logic [31:0] l3_rsp_result;
    logic [3:0]  l3_rsp_tag;

    int   checks = 0;
    int   errors = 0;
    int   n_rsp  = 0;
    rsp_t sb_q[$];
    logic hold_prev = 1'b0;
    rsp_t held;
    rsp_t mon_got;
    rsp_t mon_exp;
    logic rand_done;

    // Reference model of the external ALU: {cout, result}
    function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_INC:  return {1'b0, a} + 33'd1;
            OP_DEC:  return {1'b0, a} - 33'd1;
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOT:  return {1'b0, ~a};
            default: return {1'b1, 32'hDEAD_BEEF};
        endcase
    endfunction

    function automatic rsp_t expect_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        rsp_t r;
        logic [32:0] m;
        m = alu_model(op, a, b);
        if (op[2]) r = '{result: m[31:0], cout: m[32], tag: tag, illegal: 1'b0};
        else       r = '{result: 32'h0, cout: 1'b0, tag: tag, illegal: 1'b1};
        return r;
    endfunction

    // The ALU only produces a meaningful answer while enabled; garbage otherwise.
    assign {alu_cout, alu_result} = alu_status ? alu_model(alu_opcode, alu_a, alu_b) : {1'b1, 32'hBAD0_BAD0};
    assign {l3_alu_cout, l3_alu_result} = l3_alu_status ? alu_model(l3_alu_opcode, l3_alu_a, l3_alu_b) : {1'b1, 32'hBAD0_BAD0};

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_status(alu_status), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal)
    );

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(3), .TAG_W(4)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready), .cmd_opcode(l3_cmd_opcode),
        .cmd_a(l3_cmd_a), .cmd_b(l3_cmd_b), .cmd_tag(l3_cmd_tag),
        .alu_status(l3_alu_status), .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_opcode(l3_alu_opcode),
        .alu_result(l3_alu_result), .alu_cout(l3_alu_cout),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_result(l3_rsp_result),
        .rsp_cout(l3_rsp_cout), .rsp_tag(l3_rsp_tag), .rsp_illegal(l3_rsp_illegal)
    );

    // Scoreboard monitor for the ALU_LAT=1 instance, sampled on the falling edge.
    always @(negedge clk) begin
        mon_got = '{result: rsp_result, cout: rsp_cout, tag: rsp_tag, illegal: rsp_illegal};
        if (hold_prev && rst_n) begin
            checks++;
            if (rsp_valid !== 1'b1 || mon_got !== held) begin
                errors++;
                $display("FAIL rsp_hold: valid=%b got=%h required=%h (stable while stalled)", rsp_valid, mon_got, held);
            end
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            n_rsp++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got tag=%0d result=%h, required no response", rsp_tag, rsp_result);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL rsp_data: got res=%h cout=%b tag=%0d ill=%b, required res=%h cout=%b tag=%0d ill=%b",
                             mon_got.result, mon_got.cout, mon_got.tag, mon_got.illegal,
                             mon_exp.result, mon_exp.cout, mon_exp.tag, mon_exp.illegal);
                end else begin
                    $display("rsp tag=%0d result=%h cout=%b illegal=%b", rsp_tag, rsp_result, rsp_cout, rsp_illegal);
                end
            end
        end
        if (rst_n && cmd_valid && cmd_ready) begin
            sb_q.push_back(expect_rsp(cmd_opcode, cmd_a, cmd_b, cmd_tag));
        end
        hold_prev = rst_n && rsp_valid && !rsp_ready;
        held      = mon_got;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
            cmd_valid = 1'b0;
            return;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_l3(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        l3_cmd_valid = 1'b1; l3_cmd_opcode = op; l3_cmd_a = a; l3_cmd_b = b; l3_cmd_tag = tag;
        while (!l3_cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!l3_cmd_ready) begin
            checks++; errors++;
            $display("FAIL send_l3_timeout: cmd_ready=%b, required 1", l3_cmd_ready);
            l3_cmd_valid = 1'b0;
            return;
        end
        tick();
        l3_cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        rsp_ready = 1'b1;
        while (sb_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checks++;
        if (sb_q.size() != 0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d rsp_valid=%b, required 0 and 0", name, sb_q.size(), rsp_valid);
        end
    endtask

    task automatic test_reset();
        cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_tag = 0; rsp_ready = 0;
        l3_cmd_valid = 0; l3_cmd_opcode = 0; l3_cmd_a = 0; l3_cmd_b = 0; l3_cmd_tag = 0; l3_rsp_ready = 1;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({alu_status, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_cout, rsp_tag, rsp_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: st=%b a=%h b=%h op=%h rv=%b res=%h c=%b tag=%h ill=%b, required all 0",
                     alu_status, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_cout, rsp_tag, rsp_illegal);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || l3_cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b l3=%b rsp_valid=%b, required 1 1 0", cmd_ready, l3_cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'd3);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_early: rsp_valid=%b, required 0", rsp_valid);
        end
        tick();
        checks++;
        if (alu_status !== 1'b1 || alu_opcode !== OP_ADD || alu_a !== 32'hFFFF_FFFF || alu_b !== 32'h1) begin
            errors++;
            $display("FAIL add_drive: st=%b op=%h a=%h b=%h, required 1 f ffffffff 1", alu_status, alu_opcode, alu_a, alu_b);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_cout !== 1'b1 || rsp_tag !== 4'd3 ||
            rsp_illegal !== 1'b0 || alu_status !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: v=%b res=%h c=%b tag=%0d ill=%b st=%b, required 1 0 1 3 0 0",
                     rsp_valid, rsp_result, rsp_cout, rsp_tag, rsp_illegal, alu_status);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_handshake: rsp_valid=%b, required 0", rsp_valid);
        end
        drain("add");
    endtask

    task automatic test_backpressure();
        int base;
        base = n_rsp;
        rsp_ready = 1'b0;
        send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd1);
        send(OP_OR,  32'hF0F0_F0F0, 32'h0F00_00FF, 4'd2);
        send(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 4'd3);
        send(OP_SUB, 32'd5, 32'd7, 4'd4);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready3: cmd_ready=%b with 3 queued, required 1", cmd_ready);
        end
        send(OP_ADD, 32'd10, 32'd20, 4'd5);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full: cmd_ready=%b with 4 queued, required 0", cmd_ready);
        end
        // Offered while full: must be ignored.
        cmd_valid = 1'b1; cmd_opcode = OP_INC; cmd_a = 32'd99; cmd_b = 32'd0; cmd_tag = 4'd6;
        repeat (3) tick();
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd1) begin
            errors++; $display("FAIL bp_stall: rsp_valid=%b tag=%0d, required 1 1", rsp_valid, rsp_tag);
        end
        drain("bp");
        checks++;
        if (n_rsp - base != 5) begin
            errors++; $display("FAIL bp_count: responses=%0d, required 5", n_rsp - base);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] prev_op;
        int st_cnt = 0;
        rsp_ready = 1'b1;
        prev_op = alu_opcode;
        send(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9);
        if (alu_status) st_cnt++;
        tick();
        if (alu_status) st_cnt++;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_result !== 32'h0 || rsp_cout !== 1'b0 || rsp_tag !== 4'd9) begin
            errors++;
            $display("FAIL illegal_resp: v=%b ill=%b res=%h c=%b tag=%0d, required 1 1 0 0 9",
                     rsp_valid, rsp_illegal, rsp_result, rsp_cout, rsp_tag);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (alu_status) st_cnt++;
        end
        checks++;
        if (st_cnt != 0 || alu_opcode !== prev_op) begin
            errors++;
            $display("FAIL illegal_alu: status cycles=%0d opcode=%h, required 0 and %h", st_cnt, alu_opcode, prev_op);
        end
        drain("illegal");
    endtask

    task automatic test_latency3();
        int st_cnt = 0;
        int first_rsp = -1;
        logic in_bad = 1'b0;
        send_l3(OP_INC, 32'd7, 32'd0, 4'd12);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (l3_alu_status) begin
                st_cnt++;
                if (l3_alu_a !== 32'd7 || l3_alu_opcode !== OP_INC) in_bad = 1'b1;
            end
            if (l3_rsp_valid && first_rsp < 0) begin
                first_rsp = i;
                checks++;
                if (l3_rsp_result !== 32'd8 || l3_rsp_cout !== 1'b0 || l3_rsp_tag !== 4'd12 || l3_rsp_illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL lat3_resp: res=%h c=%b tag=%0d ill=%b, required 8 0 12 0",
                             l3_rsp_result, l3_rsp_cout, l3_rsp_tag, l3_rsp_illegal);
                end else begin
                    $display("rsp(lat3) tag=%0d result=%h cout=%b", l3_rsp_tag, l3_rsp_result, l3_rsp_cout);
                end
            end
        end
        checks++;
        if (st_cnt != 3 || in_bad) begin
            errors++; $display("FAIL lat3_status: high cycles=%0d inputs_bad=%b, required 3 0", st_cnt, in_bad);
        end
        checks++;
        if (first_rsp != 4) begin
            errors++; $display("FAIL lat3_latency: rsp_valid at cycle %0d, required 4", first_rsp);
        end
    endtask

    task automatic test_random();
        int base;
        base = n_rsp;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [31:0] a, b;
                    a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                    send(4'($urandom_range(0, 15)), a, b, 4'(i));
                    if ($urandom_range(0, 3) == 0) tick();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain("random");
        checks++;
        if (n_rsp - base != 200) begin
            errors++; $display("FAIL random_count: responses=%0d, required 200", n_rsp - base);
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        send_l3(OP_ADD, 32'd1, 32'd2, 4'd1);
        send_l3(OP_SUB, 32'd9, 32'd3, 4'd2);
        send_l3(OP_XOR, 32'd5, 32'd6, 4'd3);
        checks++;
        if (l3_alu_status !== 1'b1) begin
            errors++; $display("FAIL rstmid_drive: status=%b before reset, required 1", l3_alu_status);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (l3_alu_status !== 1'b0 || l3_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: status=%b rsp_valid=%b, required 0 0", l3_alu_status, l3_rsp_valid);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (l3_rsp_valid || l3_alu_status) seen = 1'b1;
        end
        checks++;
        if (seen || l3_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_flush: activity=%b cmd_ready=%b, required 0 1", seen, l3_cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_backpressure();
        test_illegal();
        test_latency3();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
